// File: rtl/sram_block_reader_pkg.sv
// Shared types and constants for the packet SRAM egress read engine.
// Memory geometry lives here so the reader, its FIFO and the bench agree on widths.
package sram_block_reader_pkg;

  localparam int BLOCK_BITS = 16;
  localparam int NUM_BLOCKS = 12;
  localparam int ADDR_W     = 4;
  localparam int LEN_W      = ADDR_W + 1;

  typedef logic [ADDR_W-1:0]     blk_addr_t;
  typedef logic [BLOCK_BITS-1:0] blk_data_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  // NUM_BLOCKS need not be a power of two, so the wrap is an explicit compare.
  function automatic blk_addr_t next_blk(input blk_addr_t a);
    return (a == blk_addr_t'(NUM_BLOCKS - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/sram_block_reader_if.sv
// Command, SRAM read port, output stream and free report of the block reader.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface sram_block_reader_if;
  import sram_block_reader_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  blk_addr_t            cmd_addr;
  logic [LEN_W-1:0]     cmd_len;
  blk_addr_t            sram_r_addr;
  blk_data_t            sram_r_data;
  logic                 out_valid;
  logic                 out_ready;
  blk_data_t            out_data;
  logic                 out_last;
  logic                 free_valid;
  blk_addr_t            free_addr;
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, sram_r_data, out_ready,
    output cmd_ready, sram_r_addr, out_valid, out_data, out_last,
           free_valid, free_addr, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, sram_r_data, out_ready,
    input  cmd_ready, sram_r_addr, out_valid, out_data, out_last,
           free_valid, free_addr, busy
  );

endinterface

// File: rtl/sram_block_reader_rd_fifo.sv
// Synchronous FIFO of {block address, block data} with occupancy count.
// Caller guarantees no push when full; pops on empty are ignored.
module rd_fifo
  import sram_block_reader_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  blk_addr_t        i_addr,
  input  blk_data_t        i_data,
  input  logic             i_pop,
  output blk_addr_t        o_addr,
  output blk_data_t        o_data,
  output logic [CNT_W-1:0] o_count
);

  blk_addr_t        r_addr_mem [DEPTH];
  blk_data_t        r_data_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr_mem[r_wptr] <= i_addr;
      r_data_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_addr  = r_addr_mem[r_rptr];
  assign o_data  = r_data_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_block_reader.sv
// Egress read engine: walks a run of SRAM blocks, hides the 1-cycle read latency
// behind a small FIFO and streams {addr,data} out with full backpressure.
module sram_block_reader
  import sram_block_reader_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_block_reader_if.slave   io_bus,
  output rd_state_t            o_state
);

  rd_state_t        r_state;
  blk_addr_t        r_issue_ptr;
  blk_addr_t        r_rd_addr;
  logic [LEN_W-1:0] r_issue_left;
  logic [LEN_W-1:0] r_out_left;
  logic             r_inflight;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic             w_issue;
  logic             w_valid;
  logic             w_xfer;
  blk_addr_t        w_head_addr;
  blk_data_t        w_head_data;

  // Credit counts the read in flight; a pop this cycle frees nothing until next cycle.
  assign w_occupancy = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
  assign w_issue     = (r_issue_left != '0) && (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_valid     = (w_count != '0);
  assign w_xfer      = w_valid && io_bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RD_IDLE;
      r_issue_ptr  <= '0;
      r_rd_addr    <= '0;
      r_issue_left <= '0;
      r_out_left   <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_addr    <= r_issue_ptr;
        r_issue_ptr  <= next_blk(r_issue_ptr);
        r_issue_left <= r_issue_left - 1'b1;
      end
      case (r_state)
        RD_IDLE: begin
          // Zero-length commands are consumed here and never leave IDLE.
          if (io_bus.cmd_valid && (io_bus.cmd_len != '0)) begin
            r_state      <= RD_RUN;
            r_issue_ptr  <= io_bus.cmd_addr;
            r_issue_left <= io_bus.cmd_len;
            r_out_left   <= io_bus.cmd_len;
          end
        end
        RD_RUN: begin
          if (w_xfer) begin
            r_out_left <= r_out_left - 1'b1;
            if (r_out_left == LEN_W'(1)) r_state <= RD_IDLE;
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  rd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_addr  (r_rd_addr),
    .i_data  (io_bus.sram_r_data),
    .i_pop   (w_xfer),
    .o_addr  (w_head_addr),
    .o_data  (w_head_data),
    .o_count (w_count)
  );

  assign io_bus.cmd_ready   = (r_state == RD_IDLE);
  assign io_bus.busy        = (r_state == RD_RUN);
  assign io_bus.sram_r_addr = w_issue ? r_issue_ptr : r_rd_addr;
  assign io_bus.out_valid   = w_valid;
  assign io_bus.out_data    = w_head_data;
  assign io_bus.free_addr   = w_head_addr;
  assign io_bus.out_last    = w_valid && (r_out_left == LEN_W'(1));
  assign io_bus.free_valid  = w_xfer;
  assign o_state            = r_state;

endmodule
